// File: rtl/keypad_code_ctrl.sv
// keypad_code_ctrl: collects a BCD PIN plus an ARM/DISARM key from the front-panel scanner,
// verifies it against the stored code and drives the alarm FSM's keypad input with a one-cycle command.
module keypad_code_ctrl #(
  parameter int unsigned         DIGITS         = 4,
  parameter logic [4*DIGITS-1:0] DEFAULT_PIN    = 16'h1234,
  parameter int unsigned         TIMEOUT_CYCLES = 200,
  parameter int unsigned         LOCKOUT_CYCLES = 1000,
  parameter int unsigned         MAX_FAILS      = 3
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  input  logic                pin_load,
  input  logic [4*DIGITS-1:0] pin_new,
  input  logic                is_armed,
  input  logic                is_wait_delay,
  input  logic                alarm_siren,
  output logic [3:0]          keypad,
  output logic                accept,
  output logic                reject,
  output logic                locked,
  output logic [1:0]          fail_count,
  output logic [2:0]          digit_count,
  output logic                busy
);

  localparam int unsigned   PW           = 4 * DIGITS;
  localparam int unsigned   CNT_MAX      = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES
                                                                             : LOCKOUT_CYCLES;
  localparam int unsigned   CW           = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] LOCKOUT_LOAD = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]    FULL_COUNT   = 3'(DIGITS);
  localparam logic [1:0]    FAIL_LIMIT   = 2'(MAX_FAILS);
  localparam logic [3:0]    CODE_ARM     = 4'b0011;
  localparam logic [3:0]    CODE_DISARM  = 4'b1100;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CHECK,
    ISSUE,
    LOCKOUT
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   entry_buf, entry_buf_n;
  logic [PW-1:0]   stored_pin, stored_pin_n;
  logic [CW-1:0]   timer, timer_n;
  logic            cmd_disarm, cmd_disarm_n;
  logic            short_entry, short_entry_n;
  logic [2:0]      digit_count_n;
  logic [1:0]      fail_count_n;
  logic [3:0]      keypad_n;
  logic            accept_n, reject_n, locked_n, busy_n;

  logic            key_digit, key_cmd, key_clear;
  logic            pin_match, cmd_allowed;
  logic [1:0]      fail_inc;

  assign key_digit = key_valid && (key_code <= 4'd9);
  assign key_cmd   = key_valid && ((key_code == 4'hA) || (key_code == 4'hB));
  assign key_clear = key_valid && (key_code == 4'hC);

  // A short entry is a forced mismatch regardless of what the buffer holds.
  assign pin_match   = !short_entry && (entry_buf == stored_pin);
  assign cmd_allowed = cmd_disarm ? (is_wait_delay || alarm_siren)
                                  : !(is_armed || is_wait_delay || alarm_siren);
  assign fail_inc    = (fail_count == 2'd3) ? 2'd3 : fail_count + 2'd1;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= IDLE;
      entry_buf   <= '0;
      stored_pin  <= DEFAULT_PIN;
      timer       <= '0;
      cmd_disarm  <= 1'b0;
      short_entry <= 1'b0;
      digit_count <= 3'd0;
      fail_count  <= 2'd0;
      keypad      <= 4'b0000;
      accept      <= 1'b0;
      reject      <= 1'b0;
      locked      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      entry_buf   <= entry_buf_n;
      stored_pin  <= stored_pin_n;
      timer       <= timer_n;
      cmd_disarm  <= cmd_disarm_n;
      short_entry <= short_entry_n;
      digit_count <= digit_count_n;
      fail_count  <= fail_count_n;
      keypad      <= keypad_n;
      accept      <= accept_n;
      reject      <= reject_n;
      locked      <= locked_n;
      busy        <= busy_n;
    end
  end

  always_comb begin
    state_n       = state;
    entry_buf_n   = entry_buf;
    stored_pin_n  = stored_pin;
    timer_n       = timer;
    cmd_disarm_n  = cmd_disarm;
    short_entry_n = short_entry;
    digit_count_n = digit_count;
    fail_count_n  = fail_count;
    keypad_n      = 4'b0000;
    accept_n      = 1'b0;
    reject_n      = 1'b0;
    locked_n      = locked;

    unique case (state)
      IDLE: begin
        if (pin_load) begin
          stored_pin_n = pin_new;
        end
        if (key_digit) begin
          entry_buf_n   = PW'(key_code);
          digit_count_n = 3'd1;
          timer_n       = TIMEOUT_LOAD;
          state_n       = COLLECT;
        end
      end

      // The shared timer counts down the inter-key gap; any digit, kept or dropped, reloads it.
      COLLECT: begin
        if (key_digit) begin
          if (digit_count < FULL_COUNT) begin
            entry_buf_n   = (entry_buf << 4) | PW'(key_code);
            digit_count_n = digit_count + 3'd1;
          end
          timer_n = TIMEOUT_LOAD;
        end else if (key_clear) begin
          entry_buf_n   = '0;
          digit_count_n = 3'd0;
          state_n       = IDLE;
        end else if (key_cmd) begin
          cmd_disarm_n  = (key_code == 4'hB);
          short_entry_n = (digit_count < FULL_COUNT);
          state_n       = CHECK;
        end else if (timer == '0) begin
          entry_buf_n   = '0;
          digit_count_n = 3'd0;
          state_n       = IDLE;
        end else begin
          timer_n = timer - CW'(1);
        end
      end

      CHECK: begin
        entry_buf_n   = '0;
        digit_count_n = 3'd0;
        short_entry_n = 1'b0;
        if (pin_match && cmd_allowed) begin
          keypad_n     = cmd_disarm ? CODE_DISARM : CODE_ARM;
          accept_n     = 1'b1;
          fail_count_n = 2'd0;
          state_n      = ISSUE;
        end else if (pin_match) begin
          reject_n = 1'b1;
          state_n  = IDLE;
        end else begin
          reject_n     = 1'b1;
          fail_count_n = fail_inc;
          if (fail_inc >= FAIL_LIMIT) begin
            locked_n = 1'b1;
            timer_n  = LOCKOUT_LOAD;
            state_n  = LOCKOUT;
          end else begin
            state_n = IDLE;
          end
        end
      end

      ISSUE: begin
        state_n = IDLE;
      end

      LOCKOUT: begin
        if (timer == '0) begin
          locked_n     = 1'b0;
          fail_count_n = 2'd0;
          state_n      = IDLE;
        end else begin
          timer_n = timer - CW'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule
